// File: rtl/sbox_ctr_pkg.sv
// Shared AES S-box tables (FIPS-197 forward and inverse) and the lookup helper
// used by every keystream lane of the counter-mode byte cipher.
package sbox_ctr_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t SBOX_FWD [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam byte_t SBOX_INV_TBL [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic byte_t sbox_lookup(input byte_t b, input logic inverse);
      return inverse ? SBOX_INV_TBL[b] : SBOX_FWD[b];
   endfunction

endpackage

// File: rtl/sbox_lut.sv
// One keystream lane: purely combinational S-box lookup, direction fixed at elaboration.
module sbox_lut
   import sbox_ctr_pkg::*;
#(
   parameter int SBOX_INV = 1
) (
   input  logic [7:0] addr,
   output logic [7:0] data
);

   assign data = sbox_lookup(addr, SBOX_INV != 0);

endmodule

// File: rtl/sbox_ctr_cipher.sv
// Counter-mode byte cipher: LANES bytes per beat XORed with S-box(counter + lane),
// behind a single output register with a valid/ready handshake on both sides.
module sbox_ctr_cipher
   import sbox_ctr_pkg::*;
#(
   parameter int LANES    = 4,  // 1..16 lanes per beat
   parameter int SBOX_INV = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               valid_in,
   output logic               ready_in,
   input  logic               new_message,
   input  logic [7:0]         key,
   input  logic [8*LANES-1:0] data_in,
   output logic [8*LANES-1:0] data_out,
   output logic               valid_out,
   input  logic               ready_out,
   output logic [7:0]         counter_block
);

   localparam byte_t LANE_STEP = 8'(LANES);

   byte_t              ctr_q, ctr_d;
   logic [8*LANES-1:0] data_q, data_d;
   logic               valid_q, valid_d;

   byte_t              base;
   logic [8*LANES-1:0] keystream;
   logic               in_accept;
   logic               out_accept;

   // A held beat blocks new input only while downstream is not taking it.
   assign ready_in   = !valid_q || ready_out;
   assign in_accept  = valid_in && ready_in;
   assign out_accept = valid_q && ready_out;
   assign base       = new_message ? key : ctr_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      byte_t lane_ctr;
      assign lane_ctr = base + 8'(i);

      sbox_lut #(
         .SBOX_INV (SBOX_INV)
      ) u_sbox_lut (
         .addr (lane_ctr),
         .data (keystream[8*i +: 8])
      );
   end

   // NOTE: every always_comb target gets a default first, so no latch can be inferred.
   always_comb begin
      ctr_d   = ctr_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (in_accept) begin
         ctr_d   = base + LANE_STEP;
         data_d  = data_in ^ keystream;
         valid_d = 1'b1;
      end else if (out_accept) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: the data register is reset as well, so data_out never exposes an uninitialised value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctr_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ctr_q   <= ctr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_out      = data_q;
   assign valid_out     = valid_q;
   assign counter_block = ctr_q;

endmodule

// File: tb/tb_sbox_ctr_cipher.sv
// Self-checking bench: directed vector table, stall/reset sequences and a scoreboarded
// random stream, against S-box tables rebuilt here from GF(2^8) arithmetic.
module tb_sbox_ctr_cipher;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   // Instance A: LANES=4, inverse S-box
   logic        a_valid_in = 1'b0, a_new_message = 1'b0, a_ready_out = 1'b1;
   logic [7:0]  a_key = '0;
   logic [31:0] a_data_in = '0;
   logic        a_ready_in, a_valid_out;
   logic [31:0] a_data_out;
   logic [7:0]  a_counter_block;

   // Instance B: LANES=1, forward S-box
   logic        b_valid_in = 1'b0, b_new_message = 1'b0, b_ready_out = 1'b1;
   logic [7:0]  b_key = '0;
   logic [7:0]  b_data_in = '0;
   logic        b_ready_in, b_valid_out;
   logic [7:0]  b_data_out;
   logic [7:0]  b_counter_block;

   sbox_ctr_cipher #(.LANES(4), .SBOX_INV(1)) dut_a (
      .clk           (clk),
      .reset_n       (reset_n),
      .valid_in      (a_valid_in),
      .ready_in      (a_ready_in),
      .new_message   (a_new_message),
      .key           (a_key),
      .data_in       (a_data_in),
      .data_out      (a_data_out),
      .valid_out     (a_valid_out),
      .ready_out     (a_ready_out),
      .counter_block (a_counter_block)
   );

   sbox_ctr_cipher #(.LANES(1), .SBOX_INV(0)) dut_b (
      .clk           (clk),
      .reset_n       (reset_n),
      .valid_in      (b_valid_in),
      .ready_in      (b_ready_in),
      .new_message   (b_new_message),
      .key           (b_key),
      .data_in       (b_data_in),
      .data_out      (b_data_out),
      .valid_out     (b_valid_out),
      .ready_out     (b_ready_out),
      .counter_block (b_counter_block)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] fwd_tbl [256];
   logic [7:0] inv_tbl [256];

   logic [31:0] q [$];
   logic [7:0]  m_ctr;
   int          n_acc;

   typedef struct {
      logic        v;
      logic        nm;
      logic [7:0]  key;
      logic [31:0] data;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [7:0]  exp_ctr;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] mi, s;
      for (int x = 0; x < 256; x++) begin
         mi = '0;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) mi = 8'(y);
         s = mi ^ rotl(mi, 1) ^ rotl(mi, 2) ^ rotl(mi, 3) ^ rotl(mi, 4) ^ 8'h63;
         fwd_tbl[x] = s;
         inv_tbl[s] = 8'(x);
      end
   endtask

   // One cycle on instance A, entered and left at posedge+1; outputs sampled at negedge.
   task automatic step_a(input logic v, input logic nm, input logic [7:0] k,
                         input logic [31:0] d, input logic ro);
      logic        m_ready;
      logic [7:0]  base;
      logic [31:0] exp;
      a_valid_in    = v;
      a_new_message = nm;
      a_key         = k;
      a_data_in     = d;
      a_ready_out   = ro;
      @(negedge clk);
      m_ready = (q.size() == 0) || ro;
      check("a_ready_in", {31'b0, a_ready_in}, {31'b0, m_ready});
      check("a_valid_out", {31'b0, a_valid_out}, {31'b0, q.size() != 0});
      check("a_counter_block", {24'b0, a_counter_block}, {24'b0, m_ctr});
      if (q.size() != 0) begin
         check("a_data_out", a_data_out, q[0]);
         if (ro) void'(q.pop_front());
      end
      if (v && m_ready) begin
         base = nm ? k : m_ctr;
         for (int i = 0; i < 4; i++) exp[8*i +: 8] = d[8*i +: 8] ^ inv_tbl[8'(base + 8'(i))];
         q.push_back(exp);
         m_ctr = base + 8'd4;
         n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] first_four [4];
      logic [7:0] rb;

      build_tables();

      // key ignored on the first row: a non-new_message beat after reset starts from 0x00
      vecs[0] = '{1'b1, 1'b0, 8'h55, 32'h0000_0000, 1'b1, 32'hD56A_0952, 8'h04};
      vecs[1] = '{1'b0, 1'b1, 8'h80, 32'h0000_0000, 1'b0, 32'h0000_0000, 8'h04};
      vecs[2] = '{1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF, 1'b1, 32'hC75A_C9CF, 8'h08};
      vecs[3] = '{1'b1, 1'b1, 8'hFE, 32'h0000_0000, 1'b1, 32'h0952_7D0C, 8'h02};
      vecs[4] = '{1'b1, 1'b1, 8'h6C, 32'h0000_0000, 1'b1, 32'h0645_B3B8, 8'h70};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 32'h1234_5678, 1'b1, 32'h9D2A_7AA8, 8'h74};
      vecs[6] = '{1'b1, 1'b1, 8'hAC, 32'h0000_0000, 1'b1, 32'h1BBE_18AA, 8'hB0};
      vecs[7] = '{1'b1, 1'b1, 8'hBC, 32'h0000_0000, 1'b1, 32'hF45A_CD78, 8'hC0};
      vecs[8] = '{1'b1, 1'b1, 8'h00, 32'h0000_0000, 1'b1, 32'hD56A_0952, 8'h04};
      first_four = '{8'h63, 8'h7C, 8'h77, 8'h7B};

      // Asynchronous reset takes effect without a clock edge.
      #1 reset_n = 1'b0;
      #1;
      check("rst_a_valid_out", {31'b0, a_valid_out}, 32'd0);
      check("rst_a_data_out", a_data_out, 32'd0);
      check("rst_a_counter", {24'b0, a_counter_block}, 32'd0);
      check("rst_a_ready_in", {31'b0, a_ready_in}, 32'd1);
      check("rst_b_valid_out", {31'b0, b_valid_out}, 32'd0);
      check("rst_b_counter", {24'b0, b_counter_block}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Directed table on A, back-to-back with ready_out held high.
      for (int i = 0; i < 9; i++) begin
         a_valid_in    = vecs[i].v;
         a_new_message = vecs[i].nm;
         a_key         = vecs[i].key;
         a_data_in     = vecs[i].data;
         a_ready_out   = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_valid", i), {31'b0, a_valid_out}, {31'b0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), a_data_out, vecs[i].exp_data);
         check($sformatf("vec%0d_ctr", i), {24'b0, a_counter_block}, {24'b0, vecs[i].exp_ctr});
      end
      a_valid_in = 1'b0;
      a_new_message = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      m_ctr = 8'h04;
      n_acc = 0;

      // Stall: three cycles of ready_out=0 with valid_in (and sometimes new_message) held.
      step_a(1'b1, 1'b0, 8'h00, 32'hA1A2_A3A4, 1'b1);
      for (int i = 0; i < 3; i++) step_a(1'b1, 1'(i % 2), 8'h77, 32'hB1B2_B3B4, 1'b0);
      step_a(1'b1, 1'b0, 8'h77, 32'hB1B2_B3B4, 1'b1);
      step_a(1'b1, 1'b0, 8'h00, 32'hC1C2_C3C4, 1'b1);
      step_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
      step_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);

      // Instance B: forward table walk from key 0x00; first four beats against constants.
      for (int i = 0; i < 256; i++) begin
         b_valid_in    = 1'b1;
         b_new_message = (i == 0);
         b_key         = 8'h00;
         rb            = (i < 4) ? 8'h00 : 8'($urandom);
         b_data_in     = rb;
         @(posedge clk);
         #1;
         if (i < 4) check($sformatf("b_const%0d", i), {24'b0, b_data_out}, {24'b0, first_four[i]});
         check("b_data_out", {24'b0, b_data_out}, {24'b0, rb ^ fwd_tbl[i]});
         check("b_counter", {24'b0, b_counter_block}, {24'b0, 8'(i + 1)});
      end
      b_valid_in = 1'b0;
      b_new_message = 1'b0;

      // Random stream on A until 1000 beats have been accepted.
      n_acc = 0;
      for (int c = 0; c < 6000 && n_acc < 1000; c++)
         step_a(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 8'($urandom),
                $urandom, ($urandom_range(0, 9) < 7));
      if (n_acc < 1000) check("random_accepts", n_acc, 32'd1000);
      step_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
      step_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);

      // Reset pulse while a beat is held under stall.
      step_a(1'b1, 1'b1, 8'h3C, 32'h0BAD_F00D, 1'b1);
      step_a(1'b1, 1'b0, 8'h00, 32'h1111_1111, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_a_valid_out", {31'b0, a_valid_out}, 32'd0);
      check("midrst_a_counter", {24'b0, a_counter_block}, 32'd0);
      check("midrst_a_data_out", a_data_out, 32'd0);
      check("midrst_a_ready_in", {31'b0, a_ready_in}, 32'd1);
      check("midrst_b_counter", {24'b0, b_counter_block}, 32'd0);
      a_valid_in = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      q.delete();
      m_ctr = 8'h00;
      step_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
      step_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
      step_a(1'b1, 1'b0, 8'h99, 32'h0, 1'b1);
      check("post_rst_beat", a_data_out, 32'hD56A_0952);
      step_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
      step_a(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
